uart_tx_param: RTL and testbench

//  Parametrised UART transmitter, successor to the fixed 8-bit, one-bit-per-clock TX.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_tx_param_if.sv | 13 +
 rtl/uart_baud_cnt.sv | 38 +++
 rtl/uart_tx_param.sv | 201 ++++++++++++++++++++
 tb/tb_uart_tx_param.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART transmitter.
package uart_pkg;

  localparam int unsigned MAX_DATA_WIDTH = 9;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  // Parity over a zero-extended word; zero padding does not change the XOR.
  function automatic logic par_bit(input logic [MAX_DATA_WIDTH-1:0] data, input logic typ);
    logic p;
    p = ^data;
    case (typ)
      PAR_EVEN: par_bit = p;
      PAR_ODD:  par_bit = ~p;
      default:  par_bit = p;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// Word handshake between the producer (register file / FIFO) and the transmitter.
interface uart_tx_param_if #(
  parameter int unsigned DATA_WIDTH = 8
) ();

  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_Valid;
  logic                  DATA_Ready;

  modport master (output P_DATA, output DATA_Valid, input DATA_Ready);
  modport slave  (input P_DATA, input DATA_Valid, output DATA_Ready);

endinterface

// File: rtl/uart_baud_cnt.sv
// Per-bit down counter: reloaded at each bit start, flags the last clock of the bit.
module uart_baud_cnt #(
  parameter int unsigned PRESCALE_WIDTH = 16
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      load,
  input  logic [PRESCALE_WIDTH-1:0] bitlen,
  output logic                      bit_end,
  output logic                      end_next_c
);

  logic [PRESCALE_WIDTH-1:0] cnt;
  logic [PRESCALE_WIDTH-1:0] cnt_n;

  // Counts down to 1 and parks at 0 when idle; only a reload raises it.
  always_comb begin
    cnt_n = cnt;
    if (load) begin
      cnt_n = bitlen;
    end else if (cnt != '0) begin
      cnt_n = cnt - PRESCALE_WIDTH'(1);
    end
  end

  assign end_next_c = (cnt_n == PRESCALE_WIDTH'(1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt     <= '0;
      bit_end <= 1'b0;
    end else begin
      cnt     <= cnt_n;
      bit_end <= end_next_c;
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// UART transmitter with holding register, runtime prescaler, optional parity and
// second stop bit; frames run back-to-back while the holding register stays fed.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned PRESCALE_WIDTH = 16
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic                      STOP2,
  input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
  uart_tx_param_if.slave            bus,
  output logic                      TX_OUT,
  output logic                      busy,
  output logic                      FRAME_DONE
);

  localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  tx_state_e state;
  tx_state_e state_n;

  logic                      hold_full;
  logic [DATA_WIDTH-1:0]     hold_data;
  logic [DATA_WIDTH-1:0]     shift;
  logic [IDX_W-1:0]          bit_idx;
  logic [IDX_W-1:0]          bit_idx_n;
  logic                      stop_idx;
  logic                      stop_idx_n;
  logic                      par_en_q;
  logic                      stop2_q;
  logic                      par_q;
  logic [PRESCALE_WIDTH-1:0] bitlen_q;
  logic [PRESCALE_WIDTH-1:0] bitlen_in_c;
  logic [PRESCALE_WIDTH-1:0] bitlen_sel_c;

  logic accept_c;
  logic load_word_c;
  logic baud_load_c;
  logic shift_en_c;
  logic tx_n;
  logic done_n;
  logic bit_end;
  logic end_next_c;

  assign bus.DATA_Ready = ~hold_full & ~RST;
  assign accept_c       = bus.DATA_Valid & bus.DATA_Ready;

  // A prescale of zero behaves as one clock per bit.
  assign bitlen_in_c  = (PRESCALE == '0) ? PRESCALE_WIDTH'(1) : PRESCALE;
  assign bitlen_sel_c = load_word_c ? bitlen_in_c : bitlen_q;

  uart_baud_cnt #(
    .PRESCALE_WIDTH (PRESCALE_WIDTH)
  ) u_baud (
    .CLK        (CLK),
    .RST        (RST),
    .load       (baud_load_c),
    .bitlen     (bitlen_sel_c),
    .bit_end    (bit_end),
    .end_next_c (end_next_c)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state plus next values of the registered line outputs.
  always_comb begin
    state_n     = state;
    bit_idx_n   = bit_idx;
    stop_idx_n  = stop_idx;
    tx_n        = TX_OUT;
    load_word_c = 1'b0;
    baud_load_c = 1'b0;
    shift_en_c  = 1'b0;

    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (hold_full) begin
          load_word_c = 1'b1;
          baud_load_c = 1'b1;
          state_n     = START;
          tx_n        = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_n     = DATA;
          baud_load_c = 1'b1;
          shift_en_c  = 1'b1;
          bit_idx_n   = '0;
          tx_n        = shift[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_load_c = 1'b1;
          if (bit_idx == LAST_IDX) begin
            if (par_en_q) begin
              state_n = PARITY;
              tx_n    = par_q;
            end else begin
              state_n    = STOP;
              stop_idx_n = 1'b0;
              tx_n       = 1'b1;
            end
          end else begin
            bit_idx_n  = bit_idx + IDX_W'(1);
            shift_en_c = 1'b1;
            tx_n       = shift[0];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_n     = STOP;
          baud_load_c = 1'b1;
          stop_idx_n  = 1'b0;
          tx_n        = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (stop_idx != stop2_q) begin
            stop_idx_n  = 1'b1;
            baud_load_c = 1'b1;
          end else if (hold_full) begin
            state_n     = START;
            load_word_c = 1'b1;
            baud_load_c = 1'b1;
            tx_n        = 1'b0;
          end else begin
            state_n = IDLE;
            tx_n    = 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase

    // Pulse lands on the last clock of the final stop bit.
    done_n = (state_n == STOP) && (stop_idx_n == stop2_q) && end_next_c;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      TX_OUT     <= 1'b1;
      busy       <= 1'b0;
      FRAME_DONE <= 1'b0;
    end else begin
      bit_idx    <= bit_idx_n;
      stop_idx   <= stop_idx_n;
      TX_OUT     <= tx_n;
      busy       <= (state_n != IDLE);
      FRAME_DONE <= done_n;
    end
  end

  // Holding register, shift register and per-frame configuration snapshot.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hold_full <= 1'b0;
      hold_data <= '0;
      shift     <= '0;
      par_en_q  <= 1'b0;
      stop2_q   <= 1'b0;
      par_q     <= 1'b0;
      bitlen_q  <= PRESCALE_WIDTH'(1);
    end else begin
      hold_full <= (hold_full & ~load_word_c) | accept_c;
      if (accept_c) begin
        hold_data <= bus.P_DATA;
      end
      if (load_word_c) begin
        shift    <= hold_data;
        par_en_q <= PAR_EN;
        stop2_q  <= STOP2;
        par_q    <= par_bit(MAX_DATA_WIDTH'(hold_data), PAR_TYP);
        bitlen_q <= bitlen_in_c;
      end else if (shift_en_c) begin
        shift <= shift >> 1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: frames queued at acceptance, checked clock by clock on the line.
module tb_uart_tx_param;

  logic        CLK;
  logic        RST;
  logic        PAR_EN;
  logic        PAR_TYP;
  logic        STOP2;
  logic [15:0] PRESCALE;
  logic        TX_OUT;
  logic        busy;
  logic        FRAME_DONE;

  uart_tx_param_if #(.DATA_WIDTH(8)) bus ();

  uart_tx_param #(
    .DATA_WIDTH     (8),
    .PRESCALE_WIDTH (16)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .STOP2      (STOP2),
    .PRESCALE   (PRESCALE),
    .bus        (bus),
    .TX_OUT     (TX_OUT),
    .busy       (busy),
    .FRAME_DONE (FRAME_DONE)
  );

  typedef struct {
    logic [7:0] d;
    logic       pen;
    logic       ptyp;
    logic       s2;
    int         bl;
  } frame_t;

  frame_t exp_q[$];
  int     checks      = 0;
  int     errors      = 0;
  int     frames_seen = 0;
  int     last_gap    = 0;
  int     idle_run    = 0;
  int     base;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  // Expected line for one frame; every clock of every bit is compared.
  task automatic check_frame(input frame_t f);
    logic [11:0] bits;
    logic [11:0] bit_ok;
    logic        busy_ok;
    logic        done_ok;
    int          nb;
    int          total;
    bits    = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = f.d[i];
    nb = 9;
    if (f.pen) begin
      bits[nb] = (^f.d) ^ f.ptyp;
      nb = nb + 1;
    end
    nb      = nb + 1 + (f.s2 ? 1 : 0);
    total   = nb * f.bl;
    bit_ok  = '1;
    busy_ok = 1'b1;
    done_ok = 1'b1;
    for (int k = 0; k < total; k++) begin
      if (k > 0) @(negedge CLK);
      if (RST) return;
      if (TX_OUT !== bits[k/f.bl]) bit_ok[k/f.bl] = 1'b0;
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (FRAME_DONE !== (k == total - 1)) done_ok = 1'b0;
    end
    for (int b = 0; b < nb; b++)
      chk($sformatf("line_bit%0d_of_%02h", b, f.d), 32'(bit_ok[b]), 32'd1);
    chk($sformatf("busy_in_frame_%02h", f.d), 32'(busy_ok), 32'd1);
    chk($sformatf("frame_done_%02h", f.d), 32'(done_ok), 32'd1);
    frames_seen++;
  endtask

  // Monitor: pops the next expected frame whenever a start bit appears.
  initial begin : monitor
    frame_t f;
    forever begin
      @(negedge CLK);
      if (RST) begin
        idle_run = 0;
      end else if (TX_OUT === 1'b0) begin
        last_gap = idle_run;
        idle_run = 0;
        if (exp_q.size() == 0) begin
          chk("unexpected_start", 32'(TX_OUT), 32'd1);
        end else begin
          f = exp_q.pop_front();
          check_frame(f);
        end
      end else begin
        idle_run++;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_frame_done", 32'(FRAME_DONE), 32'd0);
      end
    end
  end

  task automatic send(input logic [7:0] d, input int bl, input bit keep);
    int     n;
    frame_t f;
    n = 0;
    bus.P_DATA     = d;
    bus.DATA_Valid = 1'b1;
    while (bus.DATA_Ready !== 1'b1 && n < 1000) begin
      @(negedge CLK);
      n++;
    end
    chk("send_ready", 32'(bus.DATA_Ready), 32'd1);
    @(posedge CLK);
    f.d = d; f.pen = PAR_EN; f.ptyp = PAR_TYP; f.s2 = STOP2; f.bl = bl;
    exp_q.push_back(f);
    #1;
    if (!keep) bus.DATA_Valid = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    int c;
    c = 0;
    while (frames_seen < n && c < 2000) begin
      @(negedge CLK);
      c++;
    end
    chk("frames_seen", 32'(frames_seen), 32'(n));
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    RST            = 1'b1;
    PAR_EN         = 1'b0;
    PAR_TYP        = 1'b0;
    STOP2          = 1'b0;
    PRESCALE       = 16'd4;
    bus.P_DATA     = 8'h00;
    bus.DATA_Valid = 1'b0;

    // Reset
    repeat (3) @(negedge CLK);
    chk("reset_tx", 32'(TX_OUT), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_ready", 32'(bus.DATA_Ready), 32'd0);
    chk("reset_done", 32'(FRAME_DONE), 32'd0);
    RST = 1'b0;
    @(negedge CLK);
    chk("ready_after_reset", 32'(bus.DATA_Ready), 32'd1);

    // 0x55 even parity, one stop, plus start latency
    PAR_EN = 1'b1;
    send(8'h55, 4, 1'b0);
    chk("latency_still_idle", 32'(TX_OUT), 32'd1);
    @(posedge CLK);
    #1;
    chk("latency_start_bit", 32'(TX_OUT), 32'd0);
    chk("latency_busy", 32'(busy), 32'd1);
    wait_frames(1);

    // Odd parity, two stop bits
    PAR_TYP = 1'b1;
    STOP2   = 1'b1;
    send(8'h55, 4, 1'b0);
    wait_frames(2);

    // Back-to-back with Valid held high
    PAR_TYP = 1'b0;
    STOP2   = 1'b0;
    send(8'hA3, 4, 1'b1);
    send(8'h0F, 4, 1'b0);
    chk("ready_low_while_full", 32'(bus.DATA_Ready), 32'd0);
    wait_frames(4);
    chk("b2b_gap", 32'(last_gap), 32'd0);

    // Prescale 0, then 7 changed mid-frame
    PAR_EN   = 1'b0;
    PRESCALE = 16'd0;
    send(8'h96, 1, 1'b0);
    repeat (2) @(negedge CLK);
    PRESCALE = 16'd7;
    send(8'h3C, 7, 1'b0);
    wait_frames(6);
    chk("prescale_change_gap", 32'(last_gap), 32'd0);

    // Reset during the data bits with a word queued
    PRESCALE = 16'd4;
    PAR_EN   = 1'b1;
    send(8'h3C, 4, 1'b1);
    send(8'hE1, 4, 1'b0);
    repeat (6) @(negedge CLK);
    RST = 1'b1;
    exp_q.delete();
    @(negedge CLK);
    chk("midreset_tx", 32'(TX_OUT), 32'd1);
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_ready", 32'(bus.DATA_Ready), 32'd0);
    RST  = 1'b0;
    base = frames_seen;
    repeat (20) @(negedge CLK);
    chk("queued_word_dropped", 32'(frames_seen), 32'(base));
    chk("line_idle_after_reset", 32'(TX_OUT), 32'd1);
    PAR_EN = 1'b0;
    send(8'hC5, 4, 1'b0);
    wait_frames(base + 1);

    repeat (3) @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
